// File: rtl/uart_pkg.sv
// Types and line-level constants shared by the UART transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational frame parity: XOR of the data word, inverted for odd parity.
module uart_tx_parity_calc #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic              par_typ_i,
  output logic              par_o
);

  assign par_o = (^data_i) ^ par_typ_i;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_W data bits LSB first, optional parity, stop.
// Parity is built only when UART_TX_PARITY_EN is defined.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     p_data,
  input  logic                  data_valid,
  input  logic                  par_typ,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  uart_state_e           state_q;
  logic [PRESCALE_W-1:0] cnt_q;
  logic [PRESCALE_W-1:0] n_q;
  logic [BIT_W-1:0]      bit_q;
  logic [DATA_W-1:0]     data_q;
  logic                  tx_q;
  logic                  busy_q;

  logic                  bit_end;
  logic [BIT_W-1:0]      bit_nxt;

  assign bit_end = (cnt_q == (n_q - PRESCALE_W'(1)));
  assign bit_nxt = bit_q + BIT_W'(1);

`ifdef UART_TX_PARITY_EN
  logic par_q;
  logic par_bit;

  uart_tx_parity_calc #(.DATA_W(DATA_W)) u_parity (
    .data_i    (data_q),
    .par_typ_i (par_q),
    .par_o     (par_bit)
  );
`else
  logic unused_par_typ;
  assign unused_par_typ = par_typ;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      n_q     <= PRESCALE_W'(1);
      data_q  <= '0;
      tx_q    <= LINE_IDLE;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= PAR_EVEN;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (data_valid) begin
            data_q  <= p_data;
            // A prescale of zero would never hit a bit boundary; run it as 1.
            n_q     <= (prescale == '0) ? PRESCALE_W'(1) : prescale;
            cnt_q   <= '0;
            state_q <= START;
            tx_q    <= START_BIT;
            busy_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_typ;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= DATA;
            tx_q    <= data_q[0];
          end else begin
            cnt_q <= cnt_q + PRESCALE_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_q == BIT_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
              tx_q    <= par_bit;
`else
              state_q <= STOP;
              tx_q    <= STOP_BIT;
`endif
            end else begin
              bit_q <= bit_nxt;
              tx_q  <= data_q[bit_nxt];
            end
          end else begin
            cnt_q <= cnt_q + PRESCALE_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= STOP;
            tx_q    <= STOP_BIT;
          end else begin
            cnt_q <= cnt_q + PRESCALE_W'(1);
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            tx_q    <= LINE_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + PRESCALE_W'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
          tx_q    <= LINE_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx; expected frames follow UART_TX_PARITY_EN.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int F = 10 + PAR_EN;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_typ;
  logic [5:0] prescale;
  logic       tx_out;
  logic       busy;

  int tests = 0;
  int fails = 0;

  uart_tx #(.DATA_W(8), .PRESCALE_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_typ    (par_typ),
    .prescale   (prescale),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Drive a request before the next edge; return just after the accepting edge.
  task automatic send(input logic [7:0] d, input logic pt, input logic [5:0] ps);
    @(negedge clk);
    p_data = d; par_typ = pt; prescale = ps; data_valid = 1'b1;
    @(posedge clk);
    #1 data_valid = 1'b0;
  endtask

  // Called right after the accepting edge; checks every cycle of the frame
  // and then the first idle cycle. par is the hand-computed parity bit.
  task automatic check_frame(input string name, input logic [7:0] d,
                             input logic par, input int n);
    logic exp_bits [0:10];
    logic bad;
    logic got_tx, got_busy;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = d[i];
    if (PAR_EN != 0) exp_bits[9] = par;
    exp_bits[F-1] = 1'b1;
    for (int b = 0; b < F; b++) begin
      bad = 1'b0; got_tx = 1'b0; got_busy = 1'b0;
      for (int c = 0; c < n; c++) begin
        @(negedge clk);
        if (!bad && (tx_out !== exp_bits[b] || busy !== 1'b1)) begin
          bad = 1'b1; got_tx = tx_out; got_busy = busy;
        end
      end
      tests++;
      if (bad) begin
        fails++;
        $display("FAIL %s bit %0d: tx_out=%b busy=%b, expected tx_out=%b busy=1",
                 name, b, got_tx, got_busy, exp_bits[b]);
      end
    end
    @(negedge clk);
    tests++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s idle after stop: tx_out=%b busy=%b, expected 1/0", name, tx_out, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; data_valid = 1'b0; p_data = '0; par_typ = 1'b0; prescale = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset: tx_out=%b busy=%b, expected 1/0", tx_out, busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_even_parity();
    send(8'hA5, 1'b0, 6'd8);
    check_frame("a5_even", 8'hA5, 1'b0, 8);
  endtask

  task automatic test_odd_parity();
    send(8'hA5, 1'b1, 6'd8);
    check_frame("a5_odd", 8'hA5, 1'b1, 8);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    p_data = 8'hFF; par_typ = 1'b0; prescale = 6'd0; data_valid = 1'b1;
    @(posedge clk);
    #1 p_data = 8'h00;
    check_frame("b2b_ff", 8'hFF, 1'b0, 1);
    @(posedge clk);
    #1 data_valid = 1'b0;
    check_frame("b2b_00", 8'h00, 1'b0, 1);
  endtask

  task automatic test_drop_while_busy();
    send(8'h81, 1'b0, 6'd2);
    fork
      check_frame("drop_81", 8'h81, 1'b0, 2);
      begin
        repeat (4) @(negedge clk);
        p_data = 8'h3C; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0; p_data = 8'h81;
      end
    join
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tests++;
      if (tx_out !== 1'b1 || busy !== 1'b0) begin
        fails++;
        $display("FAIL drop_no_queue cycle %0d: tx_out=%b busy=%b, expected 1/0", c, tx_out, busy);
      end
    end
  endtask

  task automatic test_reset_abort();
    send(8'h55, 1'b0, 6'd4);
    repeat (19) @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL abort_midframe busy: busy=%b, expected 1", busy);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_reset: tx_out=%b busy=%b, expected 1/0", tx_out, busy);
    end
    rst = 1'b0;
    send(8'hC3, 1'b1, 6'd4);
    check_frame("after_abort_c3", 8'hC3, 1'b1, 4);
  endtask

  task automatic test_reset_beats_valid();
    @(negedge clk);
    rst = 1'b1; data_valid = 1'b1; p_data = 8'h0F; prescale = 6'd1;
    @(posedge clk);
    #1 rst = 1'b0; data_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_vs_valid: tx_out=%b busy=%b, expected 1/0", tx_out, busy);
    end
  endtask

  task automatic test_short_prescale();
    send(8'h01, 1'b0, 6'd2);
    check_frame("p2_01", 8'h01, 1'b1, 2);
  endtask

  task automatic test_max_prescale();
    send(8'h96, 1'b1, 6'd63);
    check_frame("p63_96", 8'h96, 1'b1, 63);
  endtask

  initial begin
    test_reset();
    test_even_parity();
    test_odd_parity();
    test_back_to_back();
    test_drop_while_busy();
    test_reset_abort();
    test_reset_beats_valid();
    test_short_prescale();
    test_max_prescale();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter for the serial link: the transmit counterpart of the receive path's start-check/sampling chain. It accepts one parallel byte per handshake and serialises it LSB-first on `tx_out` as start bit, data bits, optional parity and stop bit. Bit duration is programmable in clock cycles. The block sits between the host-side byte source and the pad driver.

## Interface
- `DATA_W`, 8: data bits per frame.
- `PRESCALE_W`, 6: width of the `prescale` input.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `p_data` input DATA_W: byte to transmit; sampled on acceptance.
- `data_valid` input 1: request to send `p_data`.
- `par_typ` input 1: parity type, 0 = even, 1 = odd; sampled on acceptance.
- `prescale` input PRESCALE_W: clock cycles per bit; sampled on acceptance; value 0 treated as 1.
- `tx_out` output 1: serial line, idle high.
- `busy` output 1: frame in progress; `data_valid` is ignored while high.

## Operation
- Reset values: `tx_out` = 1, `busy` = 0, FSM = IDLE, counters = 0.
- A request is accepted in any cycle with `data_valid` = 1 and `busy` = 0. On acceptance, capture `p_data`, `par_typ` and `prescale`. Mid-frame input changes have no effect.
- FSM states:
  - IDLE: on acceptance go to START.
  - START: after N cycles go to DATA.
  - DATA: after DATA_W bits of N cycles each, go to PARITY (parity enabled) or STOP (parity disabled).
  - PARITY: after N cycles go to STOP.
  - STOP: after N cycles go to IDLE.
- Line levels: START = 0. DATA = captured bit i, LSB first. PARITY = XOR-reduce of the captured data, XOR `par_typ`. STOP = 1. IDLE = 1.
- Counters:
  - The cycle counter (PRESCALE_W bits) counts 0..N-1 within each bit and wraps on the bit boundary.
  - The bit index (clog2(DATA_W) bits) advances only at a DATA bit boundary and clears on entry to DATA.
- `data_valid` asserted while `busy` = 1 is dropped. The block does not queue it.
- `rst` asserted mid-frame aborts the frame. On the next edge, `tx_out` = 1 and `busy` = 0. No partial stop bit is emitted.
- `rst` and `data_valid` asserted in the same cycle: reset wins and the request is not accepted.

## Timing
- All outputs are registered.
- Acceptance at edge k gives `tx_out` = 0 and `busy` = 1 from cycle k+1.
- Each bit lasts exactly N cycles.
- Frame length F = DATA_W + 2 bits, plus 1 if parity is enabled. `busy` is high for exactly F·N cycles.
- In the first cycle after the stop bit, `busy` = 0 and `tx_out` = 1. A request can be accepted in that same cycle, so back-to-back frames are separated by one idle cycle.
- N = 1 (`prescale` = 0 or 1): one bit per cycle and no stall.
- Maximum N = 2^PRESCALE_W − 1.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state, the parity logic and the `par_typ` path are compiled in.
  - Frame is DATA_W + 3 bits.
- `UART_TX_PARITY_EN` undefined:
  - DATA goes directly to STOP.
  - `par_typ` is ignored, and its register is not built.
  - Frame is DATA_W + 2 bits.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum: IDLE, START, DATA, PARITY, STOP.
  - Parity type constants: PAR_EVEN = 0, PAR_ODD = 1.
  - Line level constants: LINE_IDLE = 1, START_BIT = 0, STOP_BIT = 1.
  - These are shared with the RX side.
- One sub-module, `uart_tx_parity_calc`: combinational parity from the captured data and `par_typ`. It is instantiated only under `UART_TX_PARITY_EN`.
- FSM, counters and the output register live in `uart_tx`.

## Test plan
- Parity enabled, `prescale` = 8, `par_typ` = 0, `p_data` = 0xA5 → `tx_out` bits 0,1,0,1,0,0,1,0,1,0,1, each 8 cycles wide; `busy` high for 88 cycles; then `tx_out` = 1, `busy` = 0.
- Same, but `par_typ` = 1 → parity bit = 1; all other bits unchanged.
- `prescale` = 0, `p_data` = 0xFF, parity enabled, even → 11-cycle frame 0,1,1,1,1,1,1,1,1,0,1; a second `data_valid` with 0x00 held throughout → second start bit begins after exactly one idle cycle.
- `data_valid` pulsed with 0x3C in cycle 5 of a frame carrying 0x81 → 0x3C is never transmitted; the 0x81 frame is unchanged.
- `rst` asserted in cycle 20 of a `prescale` = 4 frame → next edge `tx_out` = 1 and `busy` = 0; next accepted frame is correct from its start bit.
- Parity disabled build, `prescale` = 2, `p_data` = 0x01 → 20-cycle frame: start 0; data 1,0,0,0,0,0,0,0; stop 1.
